// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the stream FIFO.
// Writes are synchronous on clk. Reads are asynchronous, so the word at the
// head pointer is visible in the same cycle (first-word fall-through).
module axis_fifo_ram #(
    parameter int mem_width = 8,
    parameter int width     = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [mem_width-1:0] waddr,
    input  logic [width-1:0]     wdata,
    input  logic [mem_width-1:0] raddr,
    output logic [width-1:0]     rdata
);

    localparam int DEPTH = 2 ** mem_width;

    logic [width-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO, depth 2**mem_width, no sideband signals.
// Pointers carry one extra wrap bit so that full and empty are told apart
// without an occupancy counter.
module axis_sync_fifo #(
    parameter int mem_width = 8,
    parameter int width     = 16
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [width-1:0] s_axis_tdata,
    output logic [width-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    logic [mem_width:0] wr_ptr;
    logic [mem_width:0] rd_ptr;
    logic               empty;
    logic               full;
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[mem_width] != rd_ptr[mem_width]) &&
                   (wr_ptr[mem_width-1:0] == rd_ptr[mem_width-1:0]);

    // Both flags are forced low during reset so no handshake can complete
    assign s_axis_tready = !full && !rst;
    assign m_axis_tvalid = !empty && !rst;

    assign wr_en = s_axis_tvalid && s_axis_tready;
    assign rd_en = m_axis_tvalid && m_axis_tready;

    // Advance pointers on accepted handshakes; wrap is natural modulo arithmetic
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    axis_fifo_ram #(
        .mem_width (mem_width),
        .width     (width)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[mem_width-1:0]),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr[mem_width-1:0]),
        .rdata (m_axis_tdata)
    );

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Self-checking bench for axis_sync_fifo (depth 16, 16-bit data).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_axis_sync_fifo;

    localparam int MW    = 4;
    localparam int W     = 16;
    localparam int DEPTH = 16;

    logic         rst;
    logic         clk;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [W-1:0] s_axis_tdata;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;

    int unsigned  n_cmp;
    int unsigned  n_err;
    int unsigned  count;
    int unsigned  reads;
    logic [W-1:0] exp_q [$];

    axis_sync_fifo #(
        .mem_width (MW),
        .width     (W)
    ) dut (
        .rst           (rst),
        .clk           (clk),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check flags/data against the model, update model
    task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr);
        logic wr;
        logic rd;
        @(negedge clk);
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        m_axis_tready = mr;
        #1;
        check("tready", {31'd0, s_axis_tready}, {31'd0, count != DEPTH});
        check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, count != 0});
        wr = sv && (count != DEPTH);
        rd = mr && (count != 0);
        if (rd) begin
            if (exp_q.size() == 0) begin
                check("underflow", 32'd1, 32'd0);
            end else begin
                check("tdata", {16'd0, m_axis_tdata}, {16'd0, exp_q.pop_front()});
            end
            reads++;
        end
        if (wr) begin
            exp_q.push_back(sd);
        end
        count = count + (wr ? 1 : 0) - (rd ? 1 : 0);
    endtask

    // Hold rst for one edge while presenting handshakes that must be ignored
    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hDEAD;
        m_axis_tready = 1'b1;
        #1;
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        exp_q.delete();
        count = 0;
        #1;
        check("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("post_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && count != 0; i++) begin
            step(1'b0, '0, 1'b1);
        end
        check("drained", count, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        count         = 0;
        reads         = 0;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // Reset then idle
        do_reset();
        step(1'b0, '0, 1'b0);

        // Single word with held backpressure
        step(1'b1, 16'hA5A5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            check("hold_data", {16'd0, m_axis_tdata}, 32'h0000A5A5);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Reset mid-fill with 3 words stored; those words must never reappear
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W'(16'h0100 + i), 1'b0);
        end
        do_reset();
        step(1'b1, 16'h7777, 1'b0);
        drain();

        // Fill to full, present a 17th word, then read and write together
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, W'(i), 1'b0);
        end
        step(1'b1, 16'h0099, 1'b0);
        check("full_17th", {31'd0, s_axis_tready}, 32'd0);
        step(1'b1, 16'h0099, 1'b1);
        step(1'b1, 16'h0099, 1'b0);
        drain();

        // Streaming: one word per cycle after the first, many pointer wraps
        reads = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, W'(16'h1000 + i), 1'b1);
        end
        check("stream_reads", reads, 32'd999);
        drain();

        // Random backpressure
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
